// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes,
// branch/move condition and the registered E->M pipeline stage.
module execute_stage #(
  parameter int N          = 64,
  parameter int STACK_STEP = N / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         bubble,
  input  logic         set_cc_en,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [N-1:0] valA,
  input  logic [N-1:0] valB,
  input  logic [N-1:0] valC,
  input  logic [3:0]   dstE,
  input  logic [3:0]   dstM,
  output logic [N-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         m_valid,
  output logic         m_cnd,
  output logic         m_err,
  output logic [3:0]   m_icode,
  output logic [N-1:0] m_valE,
  output logic [N-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic [2:0]   cc
);

  localparam int MSB = N - 1;
  localparam logic [N-1:0] STEP = N'(STACK_STEP);

  logic [N-1:0] w_aluA;
  logic [N-1:0] w_aluB;
  logic [1:0]   w_op;
  logic [N-1:0] w_res;
  logic         w_zf;
  logic         w_sf;
  logic         w_of;
  logic         w_cond;
  logic         w_cnd;
  logic         w_err;
  logic         w_cc_we;
  logic [3:0]   w_dstE;

  logic [2:0]   r_cc;
  logic         r_valid;
  logic         r_cnd;
  logic         r_err;
  logic [3:0]   r_icode;
  logic [N-1:0] r_valE;
  logic [N-1:0] r_valA;
  logic [3:0]   r_dstE;
  logic [3:0]   r_dstM;

  always_comb begin
    w_aluA = '0;
    w_aluB = '0;
    w_op   = 2'd0;
    unique case (icode)
      4'h2: w_aluA = valA;
      4'h3: w_aluA = valC;
      4'h4, 4'h5: begin
        w_aluA = valC;
        w_aluB = valB;
      end
      4'h6: begin
        w_aluA = valA;
        w_aluB = valB;
        w_op   = ifun[1:0];
      end
      4'h8, 4'hA: begin
        w_aluA = STEP;
        w_aluB = valB;
        w_op   = 2'd1;
      end
      4'h9, 4'hB: begin
        w_aluA = STEP;
        w_aluB = valB;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    unique case (w_op)
      2'd0: begin
        w_res = w_aluB + w_aluA;
        w_of  = (w_aluA[MSB] == w_aluB[MSB]) &&
                (w_res[MSB] != w_aluA[MSB]);
      end
      2'd1: begin
        w_res = w_aluB - w_aluA;
        w_of  = (w_aluA[MSB] != w_aluB[MSB]) &&
                (w_res[MSB] != w_aluB[MSB]);
      end
      2'd2: w_res = w_aluB & w_aluA;
      2'd3: w_res = w_aluB ^ w_aluA;
      default: ;
    endcase
  end

  assign w_zf = (w_res == '0);
  assign w_sf = w_res[MSB];

  // Condition is evaluated against the committed flags, never this op's.
  always_comb begin
    w_cond = 1'b0;
    unique case (ifun)
      4'h0: w_cond = 1'b1;
      4'h1: w_cond = (r_cc[1] ^ r_cc[0]) | r_cc[2];
      4'h2: w_cond = r_cc[1] ^ r_cc[0];
      4'h3: w_cond = r_cc[2];
      4'h4: w_cond = !r_cc[2];
      4'h5: w_cond = !(r_cc[1] ^ r_cc[0]);
      4'h6: w_cond = !(r_cc[1] ^ r_cc[0]) && !r_cc[2];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd = (icode == 4'h2 || icode == 4'h7) ? w_cond : 1'b1;

  assign w_err = (icode > 4'hB) ||
                 (icode == 4'h6 && ifun > 4'h3) ||
                 ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6);

  assign w_dstE = (icode == 4'h2 && !w_cnd) ? 4'hF : dstE;

  assign w_cc_we = in_valid && !stall && !bubble && set_cc_en &&
                   (icode == 4'h6) && !w_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cc <= 3'b100;
    end else if (w_cc_we) begin
      r_cc <= {w_zf, w_sf, w_of};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_icode <= 4'h1;
      r_cnd   <= 1'b0;
      r_err   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= 4'hF;
      r_dstM  <= 4'hF;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (bubble || !in_valid) begin
      r_valid <= 1'b0;
      r_icode <= 4'h1;
      r_cnd   <= 1'b0;
      r_err   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= 4'hF;
      r_dstM  <= 4'hF;
    end else begin
      r_valid <= 1'b1;
      r_icode <= icode;
      r_cnd   <= w_cnd;
      r_err   <= w_err;
      r_valE  <= w_res;
      r_valA  <= valA;
      r_dstE  <= w_dstE;
      r_dstM  <= dstM;
    end
  end

  assign e_valE  = w_res;
  assign e_dstE  = w_dstE;
  assign m_valid = r_valid;
  assign m_cnd   = r_cnd;
  assign m_err   = r_err;
  assign m_icode = r_icode;
  assign m_valE  = r_valE;
  assign m_valA  = r_valA;
  assign m_dstE  = r_dstE;
  assign m_dstM  = r_dstM;
  assign cc      = r_cc;

endmodule
